// File: rtl/prbs64_checker.sv
// Self-synchronising checker for the 64-bit XNOR LFSR stream (taps 63/62/60/59).
// Optional macro PRBS64_CHECKER_AUTO_RESYNC_EN: relock automatically after loss of lock instead of parking in LOST.
module prbs64_checker #(
  parameter int ERR_W       = 16,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             lock_lost
);

  localparam int WB = $clog2(WINDOW + 1);
  localparam int WE = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_CHECK   = 2'd1,
    ST_LOST    = 2'd2
  } state_t;

`ifdef PRBS64_CHECKER_AUTO_RESYNC_EN
  localparam state_t LOSS_STATE = ST_ACQUIRE;
`else
  localparam state_t LOSS_STATE = ST_LOST;
`endif

  state_t           r_state;
  logic [63:0]      r_shadow;
  logic [5:0]       r_fill;
  logic [WB-1:0]    r_win_bits;
  logic [WE-1:0]    r_win_errs;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;
  logic             r_lock_lost;

  logic             w_pred;
  logic             w_mismatch;
  logic [WB-1:0]    w_win_bits_nx;
  logic [WE-1:0]    w_win_errs_nx;
  logic             w_thresh;
  logic             w_roll;
  logic [ERR_W-1:0] w_err_count_nx;

  // Prediction, window bookkeeping and saturating error increment.
  always_comb begin
    w_pred        = ~(r_shadow[63] ^ r_shadow[62] ^ r_shadow[60] ^ r_shadow[59]);
    w_mismatch    = in_bit ^ w_pred;
    w_win_bits_nx = r_win_bits + WB'(1);
    w_win_errs_nx = r_win_errs + WE'(w_mismatch);
    w_thresh      = w_mismatch && (w_win_errs_nx >= WE'(LOSS_THRESH));
    w_roll        = (w_win_bits_nx == WB'(WINDOW));
    if (&r_err_count) begin
      w_err_count_nx = r_err_count;
    end else begin
      w_err_count_nx = r_err_count + ERR_W'(1);
    end
  end

  // Main state machine: acquire, flywheel check, loss-of-lock handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ACQUIRE;
      r_shadow    <= 64'd0;
      r_fill      <= 6'd0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_lock_lost <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_ACQUIRE;
      r_fill      <= 6'd0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_lock_lost <= 1'b0;
    end else if (!run) begin
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (in_valid) begin
        case (r_state)
          ST_ACQUIRE: begin
            r_shadow <= {r_shadow[62:0], in_bit};
            if (r_fill == 6'd63) begin
              r_state    <= ST_CHECK;
              r_locked   <= 1'b1;
              r_fill     <= 6'd0;
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else begin
              r_fill <= r_fill + 6'd1;
            end
          end
          ST_CHECK: begin
            // Shift in the prediction so one corrupted bit costs one error only.
            r_shadow <= {r_shadow[62:0], w_pred};
            if (w_mismatch) begin
              r_err_pulse <= 1'b1;
              r_err_count <= w_err_count_nx;
            end
            if (w_thresh) begin
              r_state     <= LOSS_STATE;
              r_locked    <= 1'b0;
              r_lock_lost <= 1'b1;
              r_fill      <= 6'd0;
              r_win_bits  <= '0;
              r_win_errs  <= '0;
            end else if (w_roll) begin
              r_win_bits <= '0;
              r_win_errs <= '0;
            end else begin
              r_win_bits <= w_win_bits_nx;
              r_win_errs <= w_win_errs_nx;
            end
          end
          ST_LOST: begin
            r_locked <= 1'b0;
          end
          default: begin
            r_state  <= ST_ACQUIRE;
            r_locked <= 1'b0;
            r_fill   <= 6'd0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_prbs64_checker.sv
// Directed self-checking bench for prbs64_checker: lock, single error, loss of lock,
// window rollover, gaps/enable, clear and async reset.
module tb_prbs64_checker;

  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        lock_lost;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses = 0;
  logic        gaps_en = 1'b0;
  logic [63:0] g;

  prbs64_checker #(.ERR_W(16), .WINDOW(256), .LOSS_THRESH(8)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .in_valid(in_valid), .in_bit(in_bit), .locked(locked),
    .err_pulse(err_pulse), .err_count(err_count), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference generator: XNOR feedback of taps 63/62/60/59, shifted in at bit 0.
  task automatic gen_bit(output logic b);
    b = ~(g[63] ^ g[62] ^ g[60] ^ g[59]);
    g = {g[62:0], b};
  endtask

  task automatic send(input logic flip);
    logic b;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        pulses += int'(err_pulse);
      end
    end
    gen_bit(b);
    in_valid = 1'b1;
    in_bit   = b ^ flip;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses += int'(err_pulse);
  endtask

  task automatic restart();
    clear = 1'b1;
    @(posedge clk); #1;
    clear  = 1'b0;
    g      = SEED;
    pulses = 0;
  endtask

  initial begin
    g = SEED;
    @(posedge clk); #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_lost", 32'(lock_lost), 32'd0);
    reset = 1'b0;

    // Clean lock
    for (int i = 1; i <= 63; i++) send(1'b0);
    check("clean_not_yet", 32'(locked), 32'd0);
    send(1'b0);
    check("clean_lock64", 32'(locked), 32'd1);
    for (int i = 65; i <= 300; i++) send(1'b0);
    check("clean_count", 32'(err_count), 32'd0);
    check("clean_pulses", 32'(pulses), 32'd0);

    // Single error at bit 100
    restart();
    for (int i = 1; i <= 300; i++) begin
      send(i == 100);
      if (i == 100) check("single_pulse", 32'(err_pulse), 32'd1);
      if (i == 101) check("single_pulse_off", 32'(err_pulse), 32'd0);
    end
    check("single_count", 32'(err_count), 32'd1);
    check("single_pulses", 32'(pulses), 32'd1);
    check("single_locked", 32'(locked), 32'd1);

    // Window rollover: 7 errors ending at bit 320, 7 more from bit 321
    restart();
    for (int i = 1; i <= 600; i++) begin
      send(i == 300 || i == 305 || i == 310 || i == 315 || i == 316 || i == 318 ||
           (i >= 320 && i <= 327));
    end
    check("win_locked", 32'(locked), 32'd1);
    check("win_lost", 32'(lock_lost), 32'd0);
    check("win_count", 32'(err_count), 32'd14);

    // Loss of lock: 8 consecutive errors at bits 70..77
    restart();
    for (int i = 1; i <= 77; i++) begin
      send(i >= 70);
      if (i == 76) check("loss_still_locked", 32'(locked), 32'd1);
    end
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_lost", 32'(lock_lost), 32'd1);
    check("loss_count", 32'(err_count), 32'd8);
`ifdef PRBS64_CHECKER_AUTO_RESYNC_EN
    for (int i = 78; i <= 140; i++) send(1'b0);
    check("resync_not_yet", 32'(locked), 32'd0);
    send(1'b0);
    check("resync_locked", 32'(locked), 32'd1);
    check("resync_count", 32'(err_count), 32'd8);
`else
    for (int i = 78; i <= 177; i++) send(i % 3 == 0);
    check("lost_locked", 32'(locked), 32'd0);
    check("lost_count", 32'(err_count), 32'd8);
    check("lost_pulses", 32'(pulses), 32'd8);
    check("lost_sticky", 32'(lock_lost), 32'd1);
`endif
    restart();
    check("clr_lost", 32'(lock_lost), 32'd0);
    check("clr_locked", 32'(locked), 32'd0);

    // Random gaps and a 10-cycle run-low stretch with in_valid held high
    gaps_en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      if (i == 150) begin
        run = 1'b0;
        in_valid = 1'b1;
        repeat (10) begin
          in_bit = 1'($urandom);
          @(posedge clk); #1;
        end
        check("runlow_locked", 32'(locked), 32'd1);
        check("runlow_count", 32'(err_count), 32'd1);
        run = 1'b1;
        in_valid = 1'b0;
      end
      send(i == 100);
    end
    gaps_en = 1'b0;
    check("gap_count", 32'(err_count), 32'd1);
    check("gap_pulses", 32'(pulses), 32'd1);
    check("gap_locked", 32'(locked), 32'd1);

    // Clear with a valid bit present: that bit must be discarded
    restart();
    for (int i = 1; i <= 200; i++) send(i == 80 || i == 90 || i == 100 || i == 110 || i == 120);
    check("pre_clear_count", 32'(err_count), 32'd5);
    clear = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clear_count", 32'(err_count), 32'd0);
    check("clear_locked", 32'(locked), 32'd0);
    check("clear_lost", 32'(lock_lost), 32'd0);
    g = SEED;
    for (int i = 1; i <= 63; i++) send(1'b0);
    check("clear_discard", 32'(locked), 32'd0);
    send(1'b0);
    check("clear_relock", 32'(locked), 32'd1);
    send(1'b1);
    check("pre_reset_count", 32'(err_count), 32'd1);

    // Asynchronous reset between clock edges
    #1 reset = 1'b1;
    #1;
    check("areset_locked", 32'(locked), 32'd0);
    check("areset_pulse", 32'(err_pulse), 32'd0);
    check("areset_count", 32'(err_count), 32'd0);
    check("areset_lost", 32'(lock_lost), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
